// File: rtl/start_guard.sv
// start_guard
//   Start-table register with boot-loop guard. Holds the selected start-table
//   number and an armed flag across system restarts. Each rising edge of
//   i_sys_rst is a restart that software must confirm. After MAX_RESTARTS
//   unconfirmed restarts the block trips: it disarms and loads FALLBACK_TABLE.
//
//   Optional: define START_GUARD_TIMEOUT_EN to add a confirm timeout. If
//   software stays PENDING for TIMEOUT_CYCLES cycles, o_restart_req pulses.
//
// Ports
//   i_clk         system clock
//   i_rst         async active-high power-on reset, clears everything
//   i_sys_rst     system-restart level (a long level counts once)
//   i_wr          bus write strobe, one cycle
//   i_data_in     [7:0] control {-,-,-,clear_trip,confirm,disarm,arm,set_table},
//                 [TABLE_W+7:8] table number
//   o_data_out    {tripped, pending, cnt, armed, table}
//   o_restart_req one-cycle restart request (always 0 without timeout)
module start_guard #(
   parameter int                 TABLE_W        = 8,
   parameter int                 CNT_W          = 4,
   parameter int                 MAX_RESTARTS   = 3,
   parameter logic [TABLE_W-1:0] FALLBACK_TABLE = '0,
   parameter int                 TIMEOUT_CYCLES = 1000000
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_sys_rst,
   input  logic                       i_wr,
   input  logic [TABLE_W+7:0]         i_data_in,
   output logic [TABLE_W+CNT_W+2:0]   o_data_out,
   output logic                       o_restart_req
);

   typedef enum logic [1:0] {ST_IDLE, ST_PENDING, ST_TRIPPED} state_t;

   localparam logic [31:0] MAX_U = 32'(MAX_RESTARTS);

   state_t               r_state,  w_state_nxt;
   logic [TABLE_W-1:0]   r_table,  w_table_nxt;
   logic                 r_armed,  w_armed_nxt;
   logic [CNT_W-1:0]     r_cnt,    w_cnt_nxt;
   logic                 r_sys_rst_q;

   logic                 w_evt;
   logic [CNT_W-1:0]     w_cnt_inc;
   logic                 w_set_table, w_arm, w_disarm, w_confirm, w_clear_trip;

   assign w_evt        = i_sys_rst & ~r_sys_rst_q;
   // A write colliding with a restart event is dropped entirely.
   assign w_set_table  = i_wr & ~w_evt & i_data_in[0];
   assign w_arm        = i_wr & ~w_evt & i_data_in[1];
   assign w_disarm     = i_wr & ~w_evt & i_data_in[2];
   assign w_confirm    = i_wr & ~w_evt & i_data_in[3];
   assign w_clear_trip = i_wr & ~w_evt & i_data_in[4];

   // Saturating increment so a disabled guard cannot wrap back to zero.
   assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= ST_IDLE;
         r_table     <= '0;
         r_armed     <= 1'b1;
         r_cnt       <= '0;
         r_sys_rst_q <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_table     <= w_table_nxt;
         r_armed     <= w_armed_nxt;
         r_cnt       <= w_cnt_nxt;
         r_sys_rst_q <= i_sys_rst;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_table_nxt = r_table;
      w_armed_nxt = r_armed;
      w_cnt_nxt   = r_cnt;
      if (w_evt) begin
         if (r_state != ST_TRIPPED) begin
            w_cnt_nxt = w_cnt_inc;
            if (MAX_RESTARTS != 0 && 32'(w_cnt_inc) >= MAX_U) begin
               w_state_nxt = ST_TRIPPED;
               w_armed_nxt = 1'b0;
               w_table_nxt = FALLBACK_TABLE;
            end else begin
               w_state_nxt = ST_PENDING;
               w_armed_nxt = 1'b1;
            end
         end
      end else begin
         if (w_set_table) w_table_nxt = i_data_in[TABLE_W+7:8];
         if (w_disarm)    w_armed_nxt = 1'b0;
         else if (w_arm)  w_armed_nxt = 1'b1;
         if (w_confirm && r_state == ST_PENDING) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
         end
         if (w_clear_trip && r_state == ST_TRIPPED) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
         end
      end
   end

   assign o_data_out = {r_state == ST_TRIPPED, r_state == ST_PENDING,
                        r_cnt, r_armed, r_table};

`ifdef START_GUARD_TIMEOUT_EN
   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

   logic [31:0] r_tmo;
   logic        r_restart_req;

   // Counts only while PENDING with sys_rst released; the pulse is dropped
   // if software confirms on the terminal cycle.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_tmo         <= '0;
         r_restart_req <= 1'b0;
      end else begin
         r_restart_req <= 1'b0;
         if (w_evt || r_state != ST_PENDING) begin
            r_tmo <= '0;
         end else if (!i_sys_rst) begin
            if (r_tmo == TMO_LAST) begin
               r_tmo         <= '0;
               r_restart_req <= ~w_confirm;
            end else begin
               r_tmo <= r_tmo + 1'b1;
            end
         end
      end
   end

   assign o_restart_req = r_restart_req;
`else
   logic w_unused_tmo;
   assign w_unused_tmo  = |32'(TIMEOUT_CYCLES);
   assign o_restart_req = 1'b0;
`endif

   // Control bits 7:5 are reserved.
   logic w_unused_ctl;
   assign w_unused_ctl = ^i_data_in[7:5];

endmodule

// File: doc/start_guard.md
Name: start_guard

Overview:
- Parametrised successor of the start-table register.
- Holds the selected start-table number and the armed flag across system restarts.
- Adds a boot-loop guard: counts system restarts that software has not confirmed. After MAX_RESTARTS unconfirmed restarts it disarms and forces a fallback table.
- Sits on the I/O bus next to the reset/watchdog logic. Software reads it at startup to decide which command table to run.

Parameters:
- TABLE_W, 8, width of the table number.
- CNT_W, 4, width of the restart counter.
- MAX_RESTARTS, 3, unconfirmed restarts before tripping. 0 disables the guard, so the block never trips.
- FALLBACK_TABLE, 0, table loaded on trip. Width TABLE_W.
- TIMEOUT_CYCLES, 1000000, confirm timeout. Used only with START_GUARD_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high power-on reset; clears all state
- sys_rst  in  1  synchronous system-restart level from reset logic; may last many cycles
- wr  in  1  bus write strobe, one cycle
- data_in  in  TABLE_W+8  [7:0] control bits, [TABLE_W+7:8] table number
- data_out  out  TABLE_W+CNT_W+3  {tripped, pending, cnt, armed, table}; combinational from registers
- restart_req  out  1  one-cycle restart request pulse; 0 unless timeout feature compiled in

Behaviour:
- Reset is asynchronous, active-high; all other logic on posedge clk.
- Values while and after rst: table=0, armed=1, cnt=0, state IDLE, restart_req=0, sys_rst_q=0. data_out = {0,0,0,1,0}.
- Control bits, effective only when wr=1:
  - bit0 set_table: table <= data_in[TABLE_W+7:8].
  - bit1 arm.
  - bit2 disarm; disarm wins over arm.
  - bit3 confirm.
  - bit4 clear_trip.
  - bits 7:5 are ignored.
- Restart event: rising edge of sys_rst, i.e. sys_rst & ~sys_rst_q, with sys_rst_q a registered copy. A long sys_rst counts exactly once.
- States: IDLE, PENDING, TRIPPED. data_out bit "pending" = (state==PENDING); "tripped" = (state==TRIPPED).
- Restart event in IDLE or PENDING:
  - n = cnt+1, saturating at 2^CNT_W-1.
  - If MAX_RESTARTS != 0 and n >= MAX_RESTARTS: state <= TRIPPED, armed <= 0, table <= FALLBACK_TABLE, cnt <= n.
  - Otherwise: state <= PENDING, armed <= 1, cnt <= n.
- Restart event in TRIPPED: no change.
- confirm in PENDING: cnt <= 0, state <= IDLE. confirm in IDLE or TRIPPED: no effect.
- clear_trip in TRIPPED: state <= IDLE, cnt <= 0; armed and table unchanged. clear_trip elsewhere: no effect.
- set_table, arm and disarm act in every state, including TRIPPED.
- Several control bits in one write act together. Example: set_table + confirm + arm applies all three.
- Restart event and wr in the same cycle: the restart event wins and the whole write is discarded.
- Read latency: data_out reflects a write or event on the cycle after the clock edge.
- The block survives sys_rst; only rst clears it.

Optional Feature:
- Macro: START_GUARD_TIMEOUT_EN.
- When defined, a 32-bit cycle counter:
  - Clears on every restart event and whenever state != PENDING.
  - Increments each cycle in PENDING while sys_rst=0.
  - On reaching TIMEOUT_CYCLES-1, restart_req pulses high one cycle and the counter clears. State stays PENDING; the resulting sys_rst edge is counted normally.
  - confirm in the same cycle as the terminal count suppresses the pulse.
- When undefined: no counter, restart_req tied 0, TIMEOUT_CYCLES unused.

Test Plan (defaults except FALLBACK_TABLE=8'hFF):
- Release rst -> data_out = {0,0,4'h0,1,8'h00}. Write data_in=16'h2A01 -> table=8'h2A. Write 16'h0004 -> armed=0.
- sys_rst high 5 cycles -> cnt=1, PENDING, armed=1, exactly one increment. Write 16'h0008 (confirm) -> cnt=0, IDLE.
- Three sys_rst pulses without confirm, table 8'h2A -> after third: TRIPPED, armed=0, table=8'hFF, cnt=3. Fourth pulse -> unchanged. Write 16'h0010 -> IDLE, cnt=0, armed=0.
- sys_rst rising edge in the same cycle as write 16'h0501 -> table unchanged, cnt incremented, PENDING.
- MAX_RESTARTS=0, 20 sys_rst pulses -> never TRIPPED, cnt saturates at 4'hF.
- With START_GUARD_TIMEOUT_EN and TIMEOUT_CYCLES=10: one sys_rst pulse, no confirm -> restart_req high exactly 10 cycles after PENDING entry, one cycle wide. Confirm issued at cycle 5 -> no pulse.
